cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares NUM_CDB result broadcast buses (rv_structs::data_bus[NUM_CDB]) among NUM_REQ functional-unit
//  writeback ports; feeds the ROB, reservation stations and regfile bypass.
//  Per cycle: grants up to NUM_CDB valid requesters in rotating round-robin order, packs them onto
//  bus[0..k-1] and registers the buses (1-cycle latency).
//  Fairness: a requester holding valid is granted within ceil(NUM_REQ/NUM_CDB) cycles.
// PARAMETERS
//  NUM_REQ    8   writeback requesters (ALU0, ALU1, MUL, DIV, LD, ST, BR, CSR)
//  NUM_CDB    5   broadcast buses; 1 <= NUM_CDB <= NUM_REQ
//  ROB_IDX_W  5   ROB tag width (32-entry ROB)
//  DATA_W     32  result width
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    reset; asynchronous, active-low
//  flush      in   1                    sync squash (mispredict); drops all in-flight results
//  req_valid  in   NUM_REQ              requester i has a result
//  req_rob    in   NUM_REQ x ROB_IDX_W  destination ROB tag of requester i
//  req_value  in   NUM_REQ x DATA_W     result value of requester i
//  req_ready  out  NUM_REQ              grant; transfer when req_valid[i] & req_ready[i]
//  bus        out  NUM_CDB x data_bus   {valid, dest_rob, value}, registered
//  ptr        out  $clog2(NUM_REQ)      current round-robin start index (debug/perf)
// BEHAVIOUR
//  Reset (rst=0, async): ptr=0; all bus[k].valid=0, dest_rob=0, value=0. req_ready is
//    combinational; it is 0 while rst is low.
//  Grant (combinational, same cycle):
//    - scan requesters ptr, ptr+1, ..., ptr+NUM_REQ-1 (mod NUM_REQ)
//    - the first min(NUM_CDB, popcount(req_valid)) valid ones get req_ready=1
//    - req_ready[i] is never 1 when req_valid[i]=0
//    - no grant dependence on req_rob/req_value
//  Packing: the j-th granted requester in scan order goes to slot j.
//    Next edge: bus[j] <= {1, req_rob, req_value}; unused slots get valid=0, dest_rob/value held.
//    Result visible exactly 1 cycle after handshake.
//    A bus carries valid=1 for one cycle per grant; no hold without a new grant.
//  Pointer update:
//    - grants occurred: ptr <= (index of last granted requester + 1) mod NUM_REQ
//    - no grants: ptr unchanged
//  Protocol: requester keeps valid/rob/value stable until granted. The arbiter does not check this
//    and does not dedupe identical dest_rob on two buses (both broadcast).
//  Flush: req_ready=0 in the flush cycle.
//    Next edge: all bus[k].valid <= 0, ptr unchanged.
//    Results already on bus this cycle remain visible; squashing them is the consumer's job.
//  Boundary cases:
//    - popcount <= NUM_CDB: all valid requesters granted in one cycle
//    - all NUM_REQ valid: exactly NUM_CDB granted, ptr advances by NUM_CDB (mod wrap)
//    - ptr wrap from NUM_REQ-1 to 0 is seamless
//    - reset mid-stream: outstanding requests are not granted, buses clear immediately
//    - first cycle after rst deasserts: arbitration uses ptr=0
// STRUCTURE
//  sched_structs gains:
//    - NUM_CDB, NUM_FU_WB constants
//    - cdb_req_t {valid, rob[ROB_IDX_W], value[DATA_W]}
//  rv_structs::data_bus is reused unchanged for the outputs.
//  Sub-module cdb_rr_picker (combinational):
//    inputs req_valid, ptr; outputs one-hot slot select per bus, last-grant index, grant vector.
//    Rotate -> iterative first-N pick -> un-rotate.
//  Top level holds ptr and bus registers only.
// TESTING
//  1 Reset: rst=0 mid-cycle -> bus[*].valid=0 immediately, ptr=0; after release with no req,
//    buses stay invalid.
//  2 Underload: req_valid=8'b0000_0101, rob 3/9, value 100/200 -> req_ready=8'b0000_0101 same cycle;
//    next cycle bus[0]={1,3,100}, bus[1]={1,9,200}, bus[2..4].valid=0; ptr=3.
//  3 Overload: all 8 valid, ptr=0 -> ready=8'h1F; bus[0..4] carry req 0..4; ptr=5.
//    Held requests next cycle -> req 5,6,7,0,1 granted, ptr=2.
//  4 Fairness: requester 7 held valid with requesters 0-6 continuously valid -> granted within 2 cycles.
//    Over 40 cycles each requester gets 25 grants +/-1.
//  5 Flush: 4 requests and flush=1 in the same cycle -> req_ready=0; next cycle all bus valid=0,
//    ptr unchanged.
//  6 Wrap: ptr=6, req_valid=8'b1100_0011 -> slot order 6,7,0,1; ptr becomes 2.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, writeback request and broadcast bus types for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int NUM_FU_WB = 8;
  localparam int NUM_CDB = 5;
  localparam int ROB_IDX_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [ROB_IDX_W-1:0] dest_rob;
    logic [DATA_W-1:0] value;
  } data_bus_t;
  typedef struct packed {
    logic valid;
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0] value;
  } cdb_req_t;
endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: picks the first NUM_CDB valid requesters scanning from ptr, one-hot select per bus slot
module cdb_rr_picker #(
  parameter int NUM_REQ = 8,
  parameter int NUM_CDB = 5,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] sel [NUM_CDB],
  output logic [PW-1:0]      last,
  output logic [NUM_REQ-1:0] grant
);
  int cnt;
  logic [PW:0] idx;
  always_comb begin
    grant = '0;
    last = ptr;
    cnt = 0;
    idx = '0;
    for (int k = 0; k < NUM_CDB; k++) sel[k] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
      if (req_valid[idx[PW-1:0]] && cnt < NUM_CDB) begin
        grant[idx[PW-1:0]] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) if (k == cnt) sel[k][idx[PW-1:0]] = 1'b1;
        last = idx[PW-1:0];
        cnt = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin packing of up to NUM_CDB writeback results onto registered broadcast buses
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int NUM_REQ = cdb_arbiter_pkg::NUM_FU_WB,
  parameter int NUM_CDB = cdb_arbiter_pkg::NUM_CDB,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [ROB_IDX_W-1:0] req_rob [NUM_REQ],
  input  logic [DATA_W-1:0]    req_value [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready,
  output data_bus_t            bus [NUM_CDB],
  output logic [PW-1:0]        ptr
);
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] sel [NUM_CDB];
  logic [PW-1:0] last;
  logic [ROB_IDX_W-1:0] pick_rob [NUM_CDB];
  logic [DATA_W-1:0] pick_val [NUM_CDB];
  // gating the valids keeps grants off during reset and flush without touching the picker
  cdb_rr_picker #(.NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB), .PW(PW)) u_pick (
    .req_valid(req_valid & {NUM_REQ{rst & ~flush}}),
    .ptr(ptr),
    .sel(sel),
    .last(last),
    .grant(grant)
  );
  assign req_ready = grant;
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      pick_rob[k] = '0;
      pick_val[k] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pick_rob[k] = pick_rob[k] | (sel[k][i] ? req_rob[i] : '0);
        pick_val[k] = pick_val[k] | (sel[k][i] ? req_value[i] : '0);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      for (int k = 0; k < NUM_CDB; k++) bus[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++)
        bus[k] <= |sel[k] ? {1'b1, pick_rob[k], pick_val[k]} : {1'b0, bus[k].dest_rob, bus[k].value};
      if (|grant) ptr <= (last == PW'(NUM_REQ-1)) ? '0 : last + 1'b1;
    end
  end
endmodule
